// File: rtl/param_stack_pkg.sv
// Shared definitions for the operand stack: the strobe-combination encoding
// used by the stack, the controller and the bench.
package param_stack_pkg;

  localparam int unsigned OP_W = 3;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_NONE = 3'd0;
  localparam op_t OP_PUSH = 3'd1;
  localparam op_t OP_POP  = 3'd2;
  localparam op_t OP_POP2 = 3'd3;
  localparam op_t OP_REP1 = 3'd4;
  localparam op_t OP_REP2 = 3'd5;

  // pop2 dominates pop; push combined with a pop becomes a replace
  function automatic op_t decode_op(input logic push, input logic pop, input logic pop2);
    op_t op;
    if (push) begin
      if (pop2)     op = OP_REP2;
      else if (pop) op = OP_REP1;
      else          op = OP_PUSH;
    end else begin
      if (pop2)     op = OP_POP2;
      else if (pop) op = OP_POP;
      else          op = OP_NONE;
    end
    return op;
  endfunction

endpackage

// File: rtl/param_stack_if.sv
// Controller <-> operand stack strobe and status bundle.
interface param_stack_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             push;
  logic             pop;
  logic             pop2;
  logic             tos;
  logic             clr_err;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] next;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, pop2, tos, clr_err, din,
    input  dout, top, next, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, pop2, tos, clr_err, din,
    output dout, top, next, count, empty, full, overflow, underflow
  );

endinterface

// File: rtl/param_stack_ram.sv
// Stack storage: one synchronous write port, two asynchronous read ports.
// Storage is rounded up to a power of two so addresses index it exactly.
module param_stack_ram #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [WIDTH-1:0]           wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr_a,
  input  logic [$clog2(DEPTH)-1:0]   raddr_b,
  output logic [WIDTH-1:0]           rdata_a,
  output logic [WIDTH-1:0]           rdata_b
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned SLOTS = 1 << AW;

  logic [WIDTH-1:0] mem [SLOTS];

  // Contents are never reset; unoccupied slots are masked by the stack
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/param_stack.sv
// Parametrised operand stack: push/pop/pop2/replace, tos capture,
// combinational top/next views and sticky overflow/underflow flags.
module param_stack
  import param_stack_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  param_stack_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned AW    = $clog2(DEPTH);

  logic [CNT_W-1:0] sp;
  logic [CNT_W-1:0] sp_nxt;
  logic             we;
  logic [AW-1:0]    waddr;
  logic             ovf_set;
  logic             unf_set;
  logic             has1;
  logic             has2;
  logic             is_full;
  op_t              op;
  logic [WIDTH-1:0] rd_top;
  logic [WIDTH-1:0] rd_next;
  logic [WIDTH-1:0] top_c;
  logic [WIDTH-1:0] dout_q;
  logic             ovf_q;
  logic             unf_q;

  assign op      = decode_op(bus.push, bus.pop, bus.pop2);
  assign has1    = (sp != '0);
  assign has2    = (sp >= CNT_W'(2));
  assign is_full = (sp == CNT_W'(DEPTH));

  // Guarded next-state: illegal operations leave memory and sp untouched
  always_comb begin
    sp_nxt  = sp;
    we      = 1'b0;
    waddr   = '0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    case (op)
      OP_PUSH: begin
        if (!is_full) begin
          we     = 1'b1;
          waddr  = AW'(sp);
          sp_nxt = sp + CNT_W'(1);
        end else begin
          ovf_set = 1'b1;
        end
      end
      OP_POP: begin
        if (has1) sp_nxt = sp - CNT_W'(1);
        else      unf_set = 1'b1;
      end
      OP_POP2: begin
        if (has2) sp_nxt = sp - CNT_W'(2);
        else      unf_set = 1'b1;
      end
      OP_REP1: begin
        if (has1) begin
          we    = 1'b1;
          waddr = AW'(sp - CNT_W'(1));
        end else begin
          unf_set = 1'b1;
        end
      end
      OP_REP2: begin
        if (has2) begin
          we     = 1'b1;
          waddr  = AW'(sp - CNT_W'(2));
          sp_nxt = sp - CNT_W'(1);
        end else begin
          unf_set = 1'b1;
        end
      end
      default: ;
    endcase
    if (bus.tos && !has1) unf_set = 1'b1;
  end

  // Set wins over clear on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp     <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      sp     <= sp_nxt;
      if (bus.tos && has1) dout_q <= top_c;
      ovf_q  <= ovf_set | (ovf_q & ~bus.clr_err);
      unf_q  <= unf_set | (unf_q & ~bus.clr_err);
    end
  end

  param_stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (bus.din),
    .raddr_a (AW'(sp - CNT_W'(1))),
    .raddr_b (AW'(sp - CNT_W'(2))),
    .rdata_a (rd_top),
    .rdata_b (rd_next)
  );

  assign top_c         = has1 ? rd_top : '0;
  assign bus.top       = top_c;
  assign bus.next      = has2 ? rd_next : '0;
  assign bus.count     = sp;
  assign bus.empty     = ~has1;
  assign bus.full      = is_full;
  assign bus.dout      = dout_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

endmodule
